// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the program-ROM port arbiter.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Encoding matches the bit index of each port in the arbiter request/grant vectors.
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    // Bytes returned per response on each port.
    localparam int unsigned BytesI = 3;
    localparam int unsigned BytesD = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: bit 0 is the fetch port, bit 1 the data port.
// Owns the record of which port was granted last.
module rr_arb2
    import rom_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    port_e last_q, last_d;

    // Pick a winner; on a tie the port not granted last wins.
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == PORT_D) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (advance && (gnt != 2'b00)) begin
            last_d = gnt[1] ? PORT_D : PORT_I;
        end
    end

    // Remember the last granted port; reset favours the fetch port on the first tie.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q <= PORT_D;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single ROM read port between instruction fetch and data read.
// One transaction outstanding at a time: grant, ROM access, response strobe.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned SIZE    = 2048,
    parameter logic [15:0] ROMBASE = 16'h4000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [23:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [15:0] d_rdata,
    output logic        d_err,
    output logic        rom_en,
    output logic [15:0] rom_addr,
    input  logic [23:0] rom_data
);

    // Last byte address of the window, in 17 bits so nothing wraps.
    localparam logic [16:0] WinFirst = {1'b0, ROMBASE};
    localparam logic [16:0] WinLast  = {1'b0, ROMBASE} + 17'(SIZE - 1);

    state_e      state_q, state_d;
    port_e       port_q, port_d;
    logic        inr_q, inr_d;
    logic [23:0] i_rdata_q;
    logic        i_err_q;
    logic [15:0] d_rdata_q;
    logic        d_err_q;

    logic [1:0]  arb_gnt;
    logic        advance;
    logic        i_in, d_in;
    logic [16:0] i_end, d_end;
    port_e       win_port;
    logic        win_in;
    logic [15:0] win_addr;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({d_req, i_req}),
        .advance (advance),
        .gnt     (arb_gnt)
    );

    // Window check for each port's full access span.
    always_comb begin
        i_end = {1'b0, i_addr} + 17'(BytesI - 1);
        d_end = {1'b0, d_addr} + 17'(BytesD - 1);
        i_in  = ({1'b0, i_addr} >= WinFirst) && (i_end <= WinLast);
        d_in  = ({1'b0, d_addr} >= WinFirst) && (d_end <= WinLast);
    end

    // Grant, ROM access and FSM next state.
    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        inr_d    = inr_q;
        advance  = 1'b0;
        win_port = arb_gnt[1] ? PORT_D : PORT_I;
        win_in   = arb_gnt[1] ? d_in : i_in;
        win_addr = arb_gnt[1] ? d_addr : i_addr;
        unique case (state_q)
            IDLE, RESP: begin
                // Gated by reset_n so nothing is granted while reset is held.
                advance = reset_n && (arb_gnt != 2'b00);
                if (advance) begin
                    state_d = WAIT;
                    port_d  = win_port;
                    inr_d   = win_in;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                state_d = RESP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        i_gnt    = advance && arb_gnt[0];
        d_gnt    = advance && arb_gnt[1];
        rom_en   = advance && win_in;
        rom_addr = rom_en ? win_addr : 16'h0000;
    end

    // Response strobes for the port that owns the current transaction.
    always_comb begin
        i_rvalid = reset_n && (state_q == RESP) && (port_q == PORT_I);
        d_rvalid = reset_n && (state_q == RESP) && (port_q == PORT_D);
        i_rdata  = i_rdata_q;
        i_err    = i_err_q;
        d_rdata  = d_rdata_q;
        d_err    = d_err_q;
    end

    // FSM and transaction bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            port_q  <= PORT_I;
            inr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            inr_q   <= inr_d;
        end
    end

    // Capture ROM data (or zero on a window miss) into the winner's result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            i_rdata_q <= 24'h0;
            i_err_q   <= 1'b0;
            d_rdata_q <= 16'h0;
            d_err_q   <= 1'b0;
        end else if (state_q == WAIT) begin
            if (port_q == PORT_I) begin
                i_rdata_q <= inr_q ? rom_data : 24'h0;
                i_err_q   <= !inr_q;
            end else begin
                d_rdata_q <= inr_q ? rom_data[15:0] : 16'h0;
                d_err_q   <= !inr_q;
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed scenarios plus random traffic, each cycle
// compared against a transaction-level model of the arbiter and a ROM array.
module tb_rom_port_arbiter;

    localparam int Base = 'h4000;
    localparam int Size = 2048;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req, d_req;
    logic [15:0] i_addr, d_addr;
    logic        i_gnt, i_rvalid, i_err;
    logic [23:0] i_rdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [15:0] d_rdata;
    logic        rom_en;
    logic [15:0] rom_addr;
    logic [23:0] rom_data;

    logic [7:0] mem [0:Size-1];

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    // Model state: one outstanding transaction, due two cycles after its grant.
    bit          o_valid = 0;
    bit          o_port  = 0;
    int          o_addr  = 0;
    int          o_due   = 0;
    bit          last_d  = 1;
    logic [23:0] x_i_rdata = 24'h0;
    logic        x_i_err   = 1'b0;
    logic [15:0] x_d_rdata = 16'h0;
    logic        x_d_err   = 1'b0;
    bit          g_i, g_d;
    bit          hold_reqs = 0;

    rom_port_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .i_err    (i_err),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(int a);
        if (a >= Base && a < Base + Size) return mem[a - Base];
        return 8'($urandom);
    endfunction

    // ROM: three bytes one cycle after the address; garbage when not enabled.
    always @(posedge clk) begin
        if (rom_en) begin
            rom_data <= {rom_byte(int'(rom_addr) + 2), rom_byte(int'(rom_addr) + 1),
                         rom_byte(int'(rom_addr))};
        end else begin
            rom_data <= 24'($urandom);
        end
    end

    function automatic bit in_window(int a, int n);
        return (a >= Base) && (a + n - 1 <= Base + Size - 1);
    endfunction

    function automatic logic [7:0] mem_at(int a);
        if (a >= Base && a < Base + Size) return mem[a - Base];
        return 8'h00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic cycle();
        logic        e_ig, e_dg, e_iv, e_dv, e_en;
        logic [15:0] e_ra;
        bit          pick_d;
        int          a;
        @(negedge clk);
        e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0; e_en = 0; e_ra = 16'h0;
        if (reset_n) begin
            if (o_valid && o_due == cyc) begin
                if (!o_port) begin
                    e_iv      = 1;
                    x_i_err   = !in_window(o_addr, 3);
                    x_i_rdata = x_i_err ? 24'h0 :
                        {mem_at(o_addr + 2), mem_at(o_addr + 1), mem_at(o_addr)};
                end else begin
                    e_dv      = 1;
                    x_d_err   = !in_window(o_addr, 2);
                    x_d_rdata = x_d_err ? 16'h0 : {mem_at(o_addr + 1), mem_at(o_addr)};
                end
                o_valid = 0;
            end
            if (!o_valid && (i_req || d_req)) begin
                pick_d = d_req && (!i_req || !last_d);
                a      = pick_d ? int'(d_addr) : int'(i_addr);
                if (pick_d) e_dg = 1; else e_ig = 1;
                if (in_window(a, pick_d ? 2 : 3)) begin
                    e_en = 1;
                    e_ra = 16'(a);
                end
                o_valid = 1;
                o_due   = cyc + 2;
                o_port  = pick_d;
                o_addr  = a;
                last_d  = pick_d;
            end
        end
        g_i = e_ig;
        g_d = e_dg;
        check("i_gnt", 32'(i_gnt), 32'(e_ig));
        check("d_gnt", 32'(d_gnt), 32'(e_dg));
        check("i_rvalid", 32'(i_rvalid), 32'(e_iv));
        check("d_rvalid", 32'(d_rvalid), 32'(e_dv));
        check("i_rdata", 32'(i_rdata), 32'(x_i_rdata));
        check("i_err", 32'(i_err), 32'(x_i_err));
        check("d_rdata", 32'(d_rdata), 32'(x_d_rdata));
        check("d_err", 32'(d_err), 32'(x_d_err));
        check("rom_en", 32'(rom_en), 32'(e_en));
        check("rom_addr", 32'(rom_addr), 32'(e_ra));
        // Synchronous reset takes effect at the coming edge.
        if (!reset_n) begin
            o_valid   = 0;
            last_d    = 1;
            x_i_rdata = 24'h0;
            x_i_err   = 1'b0;
            x_d_rdata = 16'h0;
            x_d_err   = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Run cycles; a requester drops its request after being granted.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            cycle();
            if (!hold_reqs) begin
                if (g_i) i_req = 1'b0;
                if (g_d) d_req = 1'b0;
            end
        end
    endtask

    task automatic issue_i(input logic [15:0] addr);
        i_req  = 1'b1;
        i_addr = addr;
        run(4);
    endtask

    task automatic issue_d(input logic [15:0] addr);
        d_req  = 1'b1;
        d_addr = addr;
        run(4);
    endtask

    function automatic logic [15:0] pick_addr();
        logic [15:0] edges [0:5];
        edges[0] = 16'h47FD; edges[1] = 16'h47FE; edges[2] = 16'h47FF;
        edges[3] = 16'h3FFF; edges[4] = 16'hFFFF; edges[5] = 16'h4000;
        case ($urandom_range(0, 3))
            0, 1:    return 16'(Base + int'($urandom_range(0, Size - 1)));
            2:       return edges[$urandom_range(0, 5)];
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        for (int k = 0; k < Size; k++) mem[k] = 8'($urandom);
        reset_n = 1'b0;
        i_req   = 1'b1;
        i_addr  = 16'h4000;
        d_req   = 1'b0;
        d_addr  = 16'h0000;
        @(posedge clk);
        #1;

        // Reset held with a pending fetch request: everything quiet.
        run(3);
        reset_n = 1'b1;
        run(4);

        // Contention: both held, grants alternate.
        hold_reqs = 1;
        i_req  = 1'b1; i_addr = 16'h4100;
        d_req  = 1'b1; d_addr = 16'h4200;
        run(12);
        hold_reqs = 0;
        i_req = 1'b0; d_req = 1'b0;
        run(3);

        // Window boundaries.
        issue_i(16'h47FD);
        issue_i(16'h47FE);
        issue_d(16'h47FE);
        issue_d(16'h47FF);
        issue_d(16'h3FFF);
        issue_d(16'hFFFF);

        // Data grant in the same cycle as the fetch response.
        i_req = 1'b1; i_addr = 16'h4010;
        run(1);
        d_req = 1'b1; d_addr = 16'h4020;
        run(5);

        // Reset while waiting on the ROM drops the transaction.
        i_req = 1'b1; i_addr = 16'h4030;
        run(1);
        reset_n = 1'b0;
        run(1);
        reset_n = 1'b1;
        run(3);
        issue_i(16'h4040);

        // Held results across idle time and the other port's response.
        issue_d(16'h4321);
        run(10);
        issue_i(16'h4400);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            if (!i_req && $urandom_range(0, 1) == 1) begin
                i_req  = 1'b1;
                i_addr = pick_addr();
            end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req  = 1'b1;
                d_addr = pick_addr();
            end
            run(1);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        run(4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
